// File: rtl/cw305_pmul_operand_ctrl.sv
// Register-bus front end for the P-256 point-multiply core: byte-wide operand
// assembly, GO/status handling, result capture, trigger generation and watchdog.
module cw305_pmul_operand_ctrl #(
  parameter int         pBYTECNT_SIZE = 8,
  parameter int         pTIMEOUT      = 2**24,
  parameter logic [4:0] pREG_GO       = 5'h00,
  parameter logic [4:0] pREG_K        = 5'h01,
  parameter logic [4:0] pREG_GX       = 5'h02,
  parameter logic [4:0] pREG_GY       = 5'h03,
  parameter logic [4:0] pREG_RX       = 5'h04,
  parameter logic [4:0] pREG_RY       = 5'h05
) (
  input  logic                     crypto_clk,
  input  logic                     reset_i,
  input  logic [4:0]               reg_addr,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic                     reg_wr,
  input  logic [7:0]               reg_wdata,
  output logic [7:0]               reg_rdata,
  output logic                     core_start,
  output logic [255:0]             core_k,
  output logic [255:0]             core_gx,
  output logic [255:0]             core_gy,
  input  logic                     core_done,
  input  logic [255:0]             core_rx,
  input  logic [255:0]             core_ry,
  output logic                     busy_o,
  output logic                     trigger_o
);
  localparam int WD_W = $clog2(pTIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state, state_nxt;

  logic [255:0]    op_k, op_gx, op_gy, res_rx, res_ry;
  logic            err_wr, err_to;
  logic [WD_W-1:0] wdog;
  logic            byte_ok, is_op, op_wr, go_wr, go_req, go_clr, timeout, idle;
  logic [4:0]      idx;
  logic [255:0]    rd_word;
  logic [7:0]      rd_byte;

  assign idx     = reg_bytecnt[4:0];
  assign byte_ok = (reg_bytecnt < 32);
  assign is_op   = (reg_addr == pREG_K) || (reg_addr == pREG_GX) || (reg_addr == pREG_GY);
  assign op_wr   = reg_wr && is_op && byte_ok;
  assign go_wr   = reg_wr && (reg_addr == pREG_GO);
  assign go_req  = go_wr && reg_wdata[0];
  assign go_clr  = go_wr && reg_wdata[2];
  assign idle    = (state == IDLE);
  // A done pulse on the final watchdog cycle still counts as completion.
  assign timeout = (state == WAIT) && !core_done && (wdog == WD_W'(pTIMEOUT - 1));

  assign busy_o     = !idle;
  assign trigger_o  = !idle;
  assign core_start = (state == START);

  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_req) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (core_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    rd_byte = 8'h00;
    if (reg_addr == pREG_GO) begin
      rd_byte = {4'b0, err_to, 1'b0, err_wr, busy_o};
    end else if (byte_ok) begin
      if      (reg_addr == pREG_K)  rd_word = op_k;
      else if (reg_addr == pREG_GX) rd_word = op_gx;
      else if (reg_addr == pREG_GY) rd_word = op_gy;
      else if (reg_addr == pREG_RX) rd_word = res_rx;
      else if (reg_addr == pREG_RY) rd_word = res_ry;
      rd_byte = rd_word[8*idx +: 8];
    end
  end

  always_ff @(posedge crypto_clk or posedge reset_i) begin
    if (reset_i) begin
      op_k      <= '0;
      op_gx     <= '0;
      op_gy     <= '0;
      res_rx    <= '0;
      res_ry    <= '0;
      core_k    <= '0;
      core_gx   <= '0;
      core_gy   <= '0;
      err_wr    <= 1'b0;
      err_to    <= 1'b0;
      wdog      <= '0;
      reg_rdata <= 8'h00;
    end else begin
      reg_rdata <= rd_byte;
      if (op_wr && idle) begin
        if      (reg_addr == pREG_K)  op_k[8*idx +: 8]  <= reg_wdata;
        else if (reg_addr == pREG_GX) op_gx[8*idx +: 8] <= reg_wdata;
        else                          op_gy[8*idx +: 8] <= reg_wdata;
      end
      // Snapshot on acceptance so core_* are already stable in the start cycle.
      if (go_req && idle) begin
        core_k  <= op_k;
        core_gx <= op_gx;
        core_gy <= op_gy;
        res_rx  <= '0;
        res_ry  <= '0;
      end
      if ((state == WAIT) && core_done) begin
        res_rx <= core_rx;
        res_ry <= core_ry;
      end
      if (state == START)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      // Setting an error wins over a clear arriving in the same cycle.
      if ((op_wr || go_req) && !idle) err_wr <= 1'b1;
      else if (go_clr)                err_wr <= 1'b0;
      if (timeout)     err_to <= 1'b1;
      else if (go_clr) err_to <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cw305_pmul_operand_ctrl.sv
// Randomized bench for cw305_pmul_operand_ctrl: event-level reference model plus
// a core model that answers after a programmable delay (or never).
module tb_cw305_pmul_operand_ctrl;
  localparam int TO = 16;
  localparam logic [255:0] GX_P256 = 256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
  localparam logic [255:0] GY_P256 = 256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   addr = '0;
  logic [7:0]   bytecnt = '0;
  logic         wr = 1'b0;
  logic [7:0]   wdata = '0;
  logic [7:0]   rdata;
  logic         core_start;
  logic [255:0] ck_o, cgx_o, cgy_o;
  logic         done_c = 1'b0, done_inj = 1'b0, done;
  logic [255:0] rx = '0, ry = '0;
  logic         busy, trig;

  always #5 clk = ~clk;
  assign done = done_c | done_inj;

  cw305_pmul_operand_ctrl #(.pBYTECNT_SIZE(8), .pTIMEOUT(TO)) dut (
    .crypto_clk(clk), .reset_i(rst), .reg_addr(addr), .reg_bytecnt(bytecnt),
    .reg_wr(wr), .reg_wdata(wdata), .reg_rdata(rdata), .core_start(core_start),
    .core_k(ck_o), .core_gx(cgx_o), .core_gy(cgy_o), .core_done(done),
    .core_rx(rx), .core_ry(ry), .busy_o(busy), .trigger_o(trig)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model (event level) ----------------
  logic [255:0] m_op [3];
  logic [255:0] m_snap [3];
  logic [255:0] m_rx = '0, m_ry = '0;
  bit           m_busy = 0, m_errw = 0, m_errto = 0;
  int           m_age = 0;
  logic [7:0]   exp_rdata = '0;
  int           cyc = 0;

  function automatic logic [7:0] model_read(input logic [4:0] a, input logic [7:0] b);
    logic [255:0] w;
    w = '0;
    if (a == 5'd0) return {4'b0, m_errto, 1'b0, m_errw, m_busy};
    if (b > 8'd31) return 8'h00;
    case (a)
      5'd1: w = m_op[0];
      5'd2: w = m_op[1];
      5'd3: w = m_op[2];
      5'd4: w = m_rx;
      5'd5: w = m_ry;
      default: return 8'h00;
    endcase
    return w[8*b +: 8];
  endfunction

  always @(posedge clk) begin
    bit was_busy;
    cyc++;
    exp_rdata = rst ? 8'h00 : model_read(addr, bytecnt);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_op[i] = '0; m_snap[i] = '0; end
      m_rx = '0; m_ry = '0; m_busy = 0; m_errw = 0; m_errto = 0; m_age = 0;
    end else begin
      was_busy = m_busy;
      if (wr && addr == 5'd0 && wdata[2]) begin m_errw = 0; m_errto = 0; end
      if (was_busy) begin
        // age 0 is the start cycle; ages 1..TO are the cycles the core may answer in
        if (m_age >= 1 && done) begin m_rx = rx; m_ry = ry; m_busy = 0; end
        else if (m_age == TO) begin m_errto = 1; m_busy = 0; end
        else m_age++;
      end
      if (wr && addr >= 5'd1 && addr <= 5'd3 && bytecnt < 8'd32) begin
        if (was_busy) m_errw = 1;
        else m_op[addr - 5'd1][8*bytecnt +: 8] = wdata;
      end
      if (wr && addr == 5'd0 && wdata[0]) begin
        if (was_busy) m_errw = 1;
        else begin
          m_busy = 1; m_age = 0; m_rx = '0; m_ry = '0;
          for (int i = 0; i < 3; i++) m_snap[i] = m_op[i];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int n_start = 0, start_cyc = -1, go_cyc = -10;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_trigger", trig, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_rdata", rdata, 0);
    end else begin
      chk("busy", busy, m_busy);
      chk("trigger", trig, m_busy);
      chk("core_start", core_start, m_busy && m_age == 0);
      chk("rdata", rdata, exp_rdata);
      if (m_busy) begin
        chk("core_k", ck_o, m_snap[0]);
        chk("core_gx", cgx_o, m_snap[1]);
        chk("core_gy", cgy_o, m_snap[2]);
      end
    end
    if (core_start) begin n_start++; start_cyc = cyc; end
  end

  // ---------------- core model: rx = k ^ gx, ry = k + gy ----------------
  int core_mode = 0, core_dly = 4;
  bit core_active = 0;
  initial begin
    logic [255:0] mk, mgx, mgy;
    forever begin
      @(negedge clk);
      if (core_start) begin
        core_active = 1;
        mk = ck_o; mgx = cgx_o; mgy = cgy_o;
        if (core_mode == 0) begin
          @(posedge clk);
          repeat (core_dly - 1) @(posedge clk);
          #1 done_c = 1'b1; rx = mk ^ mgx; ry = mk + mgy;
          @(posedge clk);
          #1 done_c = 1'b0; rx = rnd256(); ry = rnd256();
        end
        core_active = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr_byte(input logic [4:0] a, input int b, input logic [7:0] d);
    addr = a; bytecnt = 8'(b); wdata = d; wr = 1'b1;
    if (a == 5'd0 && d[0]) go_cyc = cyc;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wr_op(input logic [4:0] a, input logic [255:0] v);
    for (int b = 0; b < 32; b++) wr_byte(a, b, v[8*b +: 8]);
  endtask

  task automatic rd(input logic [4:0] a, input int b, output logic [7:0] v);
    addr = a; bytecnt = 8'(b);
    @(posedge clk); #1;
    v = rdata;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || core_active) && n < 300) begin @(posedge clk); #1; n++; end
    chk({name, "_idle_bound"}, n < 300, 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int n, n0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset wipes randomly written operands
    for (int r = 1; r <= 3; r++) wr_op(5'(r), rnd256());
    pulse_rst();
    for (int a = 0; a < 7; a++) begin
      rd(5'(a), 0, v);  chk("rst_read_b0", v, 8'h00);
      rd(5'(a), 31, v); chk("rst_read_b31", v, 8'h00);
    end
    chk("rst_no_start", n_start, 0);

    // hand-computed operation
    wr_byte(5'd1, 0, 8'h12); wr_byte(5'd2, 0, 8'h34); wr_byte(5'd3, 0, 8'hF0);
    wr_byte(5'd1, 32, 8'hEE);
    core_dly = 2;
    wr_byte(5'd0, 0, 8'h01);
    wait_idle("lit");
    chk("lit_start_count", n_start, 1);
    chk("lit_start_latency", start_cyc, go_cyc + 1);
    rd(5'd4, 0, v); chk("lit_rx_b0", v, 8'h26);
    rd(5'd4, 1, v); chk("lit_rx_b1", v, 8'h00);
    rd(5'd5, 0, v); chk("lit_ry_b0", v, 8'h02);
    rd(5'd5, 1, v); chk("lit_ry_b1", v, 8'h01);
    rd(5'd1, 32, v); chk("lit_bytecnt_oob", v, 8'h00);
    rd(5'd7, 0, v); chk("lit_bad_addr", v, 8'h00);

    // generator point operands with random scalar
    wr_op(5'd1, rnd256()); wr_op(5'd2, GX_P256); wr_op(5'd3, GY_P256);
    core_dly = 9;
    n0 = n_start;
    wr_byte(5'd0, 0, 8'h01);
    wait_idle("gen");
    chk("gen_start_latency", start_cyc, go_cyc + 1);
    chk("gen_start_count", n_start - n0, 1);
    for (int b = 0; b < 32; b += 3) begin rd(5'd4, b, v); rd(5'd5, b, v); end

    // randomized transactions
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(1, 8)) wr_byte(5'($urandom_range(1, 3)), $urandom_range(0, 40), 8'($urandom));
      core_dly = $urandom_range(1, 20);
      wr_byte(5'd0, 0, 8'($urandom_range(0, 1) * 4 + 1));
      repeat ($urandom_range(0, 6)) begin
        if ($urandom_range(0, 1) == 1) wr_byte(5'($urandom_range(0, 3)), $urandom_range(0, 35), 8'($urandom));
        else rd(5'($urandom_range(0, 6)), $urandom_range(0, 35), v);
      end
      wait_idle("rand");
      for (int b = 0; b < 32; b += 7) begin rd(5'd4, b, v); rd(5'd5, b, v); end
      rd(5'd0, 0, v);
    end

    // dropped write while busy, then error clear
    pulse_rst();
    wr_byte(5'd1, 0, 8'h5A);
    core_dly = 10;
    wr_byte(5'd0, 0, 8'h01);
    wr_byte(5'd1, 0, 8'hAA);
    chk("busy_core_k_b0", ck_o[7:0], 8'h5A);
    rd(5'd0, 0, v); chk("err_wr_busy", v, 8'h03);
    wait_idle("err");
    rd(5'd0, 0, v); chk("err_wr_idle", v, 8'h02);
    rd(5'd1, 0, v); chk("k_kept", v, 8'h5A);
    wr_byte(5'd0, 0, 8'h04);
    rd(5'd0, 0, v); chk("err_cleared", v, 8'h00);

    // watchdog: core never answers
    core_mode = 1;
    wr_byte(5'd0, 0, 8'h01);
    n = 0;
    while (busy && n < 100) begin n++; @(posedge clk); #1; end
    chk("timeout_busy_cycles", n, 17);
    rd(5'd0, 0, v); chk("timeout_status", v, 8'h08);
    rd(5'd4, 0, v); chk("timeout_rx0", v, 8'h00);
    rd(5'd5, 5, v); chk("timeout_ry5", v, 8'h00);
    core_mode = 0;

    // stray done in IDLE and repeated GO while busy
    wr_byte(5'd0, 0, 8'h04);
    done_inj = 1'b1; @(posedge clk); #1; done_inj = 1'b0;
    rd(5'd4, 0, v); chk("stray_done_rx", v, 8'h00);
    n0 = n_start;
    core_dly = 8;
    repeat (4) wr_byte(5'd0, 0, 8'h01);
    wait_idle("rego");
    chk("rego_one_start", n_start - n0, 1);
    rd(5'd0, 0, v); chk("rego_status", v, 8'h02);

    // reset during WAIT, then a fresh operation
    wr_byte(5'd0, 0, 8'h04);
    wr_op(5'd1, rnd256());
    core_dly = 12;
    wr_byte(5'd0, 0, 8'h01);
    repeat (4) begin @(posedge clk); #1; end
    n0 = n_start;
    rst = 1'b1;
    @(negedge clk); chk("rst_wait_busy", busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    wait_idle("rstw");
    chk("rst_no_reissue", n_start - n0, 0);
    rd(5'd4, 0, v); chk("rstw_rx0", v, 8'h00);
    rd(5'd5, 9, v); chk("rstw_ry9", v, 8'h00);
    wr_byte(5'd2, 0, 8'h0F); wr_byte(5'd1, 0, 8'hF0);
    core_dly = 3;
    wr_byte(5'd0, 0, 8'h01);
    wait_idle("fresh");
    chk("fresh_one_start", n_start - n0, 1);
    rd(5'd4, 0, v); chk("fresh_rx0", v, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
